// File: rtl/player_move_ctl_pkg.sv
// Shared definitions for the maze playfield: the default geometry, direction
// codes, the movement FSM states and the colours also used by the background stage.
package player_move_ctl_pkg;

    localparam int PF_X_MIN = 62;
    localparam int PF_Y_MIN = 108;
    localparam int PF_TILE  = 60;
    localparam int PF_COLS  = 15;
    localparam int PF_ROWS  = 10;
    localparam int PF_STEP  = 4;

    localparam logic [11:0] COLOR_BG     = 12'h000;
    localparam logic [11:0] COLOR_WALL   = 12'h00F;
    localparam logic [11:0] COLOR_PLAYER = 12'hFF0;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic {
        ST_IDLE,
        ST_MOVE
    } move_state_e;

    // Pixel coordinate of the top-left corner of tile idx along one axis
    function automatic logic [10:0] tile_origin(input int base, input int idx, input int tile);
        return 11'(base + idx * tile);
    endfunction

endpackage

// File: rtl/player_move_ctl_frame_tick.sv
// frame_tick_gen: turns the vsync level into a one-cycle frame strobe on its
// rising edge. A vsync that is already high when reset is released does not
// count as an edge; the detector arms only after seeing vsync low.
module frame_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_in,
    output logic tick
);

    logic vsync_d;
    logic armed;

    // Delay vsync by one clock and remember once it has been seen low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d <= 1'b0;
            armed   <= 1'b0;
        end else begin
            vsync_d <= vsync_in;
            if (!vsync_in) begin
                armed <= 1'b1;
            end
        end
    end

    assign tick = vsync_in & ~vsync_d & armed;

endmodule

// File: rtl/player_move_ctl.sv
// player_move_ctl: tile-grid movement controller for the player sprite.
// On each frame tick an idle player accepts one button (up > down > left > right)
// and then slides one whole tile, STEP pixels per frame. Requests that would leave
// the playfield are refused with a one-cycle blocked pulse.
// Optional feature macro PLAYER_WRAP_EN: edge requests wrap to the opposite side
// in a single tick instead of being refused.
module player_move_ctl
    import player_move_ctl_pkg::*;
#(
    parameter int X_MIN     = PF_X_MIN,
    parameter int Y_MIN     = PF_Y_MIN,
    parameter int TILE      = PF_TILE,
    parameter int COLS      = PF_COLS,
    parameter int ROWS      = PF_ROWS,
    parameter int STEP      = PF_STEP,
    parameter int START_COL = 0,
    parameter int START_ROW = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync_in,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        moving,
    output logic [1:0]  dir,
    output logic        blocked
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int SW = $clog2(TILE + 1);

    localparam logic [10:0] X_RST = tile_origin(X_MIN, START_COL, TILE);
    localparam logic [10:0] Y_RST = tile_origin(Y_MIN, START_ROW, TILE);
    localparam logic [10:0] STEP_PX = 11'(STEP);

`ifdef PLAYER_WRAP_EN
    localparam logic [10:0] X_MAX = tile_origin(X_MIN, COLS - 1, TILE);
    localparam logic [10:0] Y_MAX = tile_origin(Y_MIN, ROWS - 1, TILE);
`endif

    logic tick;

    move_state_e     state, state_n;
    logic [CW-1:0]   col, col_n;
    logic [RW-1:0]   row, row_n;
    logic [SW-1:0]   step_cnt, step_n, step_sum;
    logic [10:0]     xpos_n, ypos_n;
    logic            moving_n;
    logic            blocked_n;
    dir_e            dir_q, dir_n;

    logic            req;
    dir_e            req_dir;
    logic            at_edge;

    frame_tick_gen u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .vsync_in (vsync_in),
        .tick     (tick)
    );

    assign dir = dir_q;

    // State, grid position and all outputs update together from the next-state logic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            col      <= CW'(START_COL);
            row      <= RW'(START_ROW);
            step_cnt <= '0;
            xpos     <= X_RST;
            ypos     <= Y_RST;
            moving   <= 1'b0;
            dir_q    <= DIR_UP;
            blocked  <= 1'b0;
        end else begin
            state    <= state_n;
            col      <= col_n;
            row      <= row_n;
            step_cnt <= step_n;
            xpos     <= xpos_n;
            ypos     <= ypos_n;
            moving   <= moving_n;
            dir_q    <= dir_n;
            blocked  <= blocked_n;
        end
    end

    // Button arbitration, edge check, and the IDLE/MOVE next-state and datapath
    always_comb begin
        state_n   = state;
        col_n     = col;
        row_n     = row;
        step_n    = step_cnt;
        xpos_n    = xpos;
        ypos_n    = ypos;
        moving_n  = moving;
        dir_n     = dir_q;
        blocked_n = 1'b0;
        step_sum  = step_cnt + SW'(STEP);

        req     = 1'b1;
        req_dir = DIR_UP;
        at_edge = 1'b0;
        if (btn_up) begin
            req_dir = DIR_UP;
            at_edge = (row == '0);
        end else if (btn_down) begin
            req_dir = DIR_DOWN;
            at_edge = (row == RW'(ROWS - 1));
        end else if (btn_left) begin
            req_dir = DIR_LEFT;
            at_edge = (col == '0);
        end else if (btn_right) begin
            req_dir = DIR_RIGHT;
            at_edge = (col == CW'(COLS - 1));
        end else begin
            req = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (tick && req) begin
                    dir_n = req_dir;
                    if (!at_edge) begin
                        state_n  = ST_MOVE;
                        moving_n = 1'b1;
                        step_n   = '0;
                    end else begin
`ifdef PLAYER_WRAP_EN
                        case (req_dir)
                            DIR_UP:    begin row_n = RW'(ROWS - 1); ypos_n = Y_MAX; end
                            DIR_DOWN:  begin row_n = '0;            ypos_n = 11'(Y_MIN); end
                            DIR_LEFT:  begin col_n = CW'(COLS - 1); xpos_n = X_MAX; end
                            default:   begin col_n = '0;            xpos_n = 11'(X_MIN); end
                        endcase
`else
                        blocked_n = 1'b1;
`endif
                    end
                end
            end
            ST_MOVE: begin
                if (tick) begin
                    case (dir_q)
                        DIR_UP:    ypos_n = ypos - STEP_PX;
                        DIR_DOWN:  ypos_n = ypos + STEP_PX;
                        DIR_LEFT:  xpos_n = xpos - STEP_PX;
                        default:   xpos_n = xpos + STEP_PX;
                    endcase
                    step_n = step_sum;
                    if (step_sum == SW'(TILE)) begin
                        case (dir_q)
                            DIR_UP:    row_n = row - RW'(1);
                            DIR_DOWN:  row_n = row + RW'(1);
                            DIR_LEFT:  col_n = col - CW'(1);
                            default:   col_n = col + CW'(1);
                        endcase
                        state_n  = ST_IDLE;
                        moving_n = 1'b0;
                        step_n   = '0;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
